// File: rtl/av2_axi_mem_slave_if.sv
// Simplified AXI4 write/read channel bundle for the av2 frame buffer memory port.
interface av2_axi_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic [7:0]            s_axi_awlen;
  logic                  s_axi_awvalid;
  logic                  s_axi_awready;
  logic [DATA_WIDTH-1:0] s_axi_wdata;
  logic                  s_axi_wlast;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic [7:0]            s_axi_arlen;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [DATA_WIDTH-1:0] s_axi_rdata;
  logic                  s_axi_rlast;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awlen, s_axi_awvalid, input s_axi_awready,
    output s_axi_wdata, s_axi_wlast, s_axi_wvalid, input s_axi_wready,
    input s_axi_bresp, s_axi_bvalid, output s_axi_bready,
    output s_axi_araddr, s_axi_arlen, s_axi_arvalid, input s_axi_arready,
    input s_axi_rdata, s_axi_rlast, s_axi_rresp, s_axi_rvalid, output s_axi_rready
  );

  modport slave (
    input s_axi_awaddr, s_axi_awlen, s_axi_awvalid, output s_axi_awready,
    input s_axi_wdata, s_axi_wlast, s_axi_wvalid, output s_axi_wready,
    output s_axi_bresp, s_axi_bvalid, input s_axi_bready,
    input s_axi_araddr, s_axi_arlen, s_axi_arvalid, output s_axi_arready,
    output s_axi_rdata, s_axi_rlast, s_axi_rresp, s_axi_rvalid, input s_axi_rready
  );
endinterface

// File: rtl/av2_axi_mem_slave.sv
// Simplified AXI4 INCR-burst responder with word-addressed backing store; the
// write and read channels are independent FSMs sharing only the memory array.
module av2_axi_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int MEM_WORDS  = 1024
) (
  input logic                clk,
  input logic                rst_n,
  av2_axi_mem_slave_if.slave s_axi
);
  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(MEM_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // ---------------- write channel ----------------
  w_state_t              w_state, w_next;
  logic [ADDR_WIDTH-1:0] w_addr, w_beat;
  logic [7:0]            w_len, w_cnt;
  logic                  w_err, w_in_range, w_last_beat, aw_hs, w_hs;

  assign w_beat      = w_addr + ADDR_WIDTH'(w_cnt);
  assign w_in_range  = w_beat < DEPTH;
  assign w_last_beat = w_cnt == w_len;
  assign aw_hs       = s_axi.s_axi_awvalid && s_axi.s_axi_awready;
  assign w_hs        = s_axi.s_axi_wvalid && s_axi.s_axi_wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next              = w_state;
    s_axi.s_axi_awready = 1'b0;
    s_axi.s_axi_wready  = 1'b0;
    s_axi.s_axi_bvalid  = 1'b0;
    s_axi.s_axi_bresp   = RESP_OKAY;
    case (w_state)
      W_IDLE: begin
        s_axi.s_axi_awready = 1'b1;
        if (s_axi.s_axi_awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        s_axi.s_axi_wready = 1'b1;
        if (s_axi.s_axi_wvalid && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        s_axi.s_axi_bvalid = 1'b1;
        s_axi.s_axi_bresp  = w_err ? RESP_SLVERR : RESP_OKAY;
        if (s_axi.s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_addr <= '0;
      w_len  <= '0;
      w_cnt  <= '0;
      w_err  <= 1'b0;
    end else if (aw_hs) begin
      w_addr <= s_axi.s_axi_awaddr;
      w_len  <= s_axi.s_axi_awlen;
      w_cnt  <= '0;
      w_err  <= 1'b0;
    end else if (w_hs) begin
      w_cnt <= w_cnt + 8'd1;
      // wlast must coincide exactly with the len-terminated final beat
      if (!w_in_range || (s_axi.s_axi_wlast != w_last_beat)) w_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && w_in_range) mem[w_beat[IDX_W-1:0]] <= s_axi.s_axi_wdata;
  end

  // ---------------- read channel ----------------
  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr, r_beat, r_load_addr;
  logic [7:0]            r_len, r_cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  r_last_beat, r_load_ok, ar_hs, r_hs;

  assign r_beat      = r_addr + ADDR_WIDTH'(r_cnt);
  assign r_last_beat = r_cnt == r_len;
  assign ar_hs       = s_axi.s_axi_arvalid && s_axi.s_axi_arready;
  assign r_hs        = s_axi.s_axi_rvalid && s_axi.s_axi_rready;
  // rdata is registered one beat ahead: load the start word on AR, the next word on R
  assign r_load_addr = ar_hs ? s_axi.s_axi_araddr : r_beat + ADDR_WIDTH'(1);
  assign r_load_ok   = r_load_addr < DEPTH;

  assign s_axi.s_axi_rdata = rdata_q;
  assign s_axi.s_axi_rresp = rresp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next              = r_state;
    s_axi.s_axi_arready = 1'b0;
    s_axi.s_axi_rvalid  = 1'b0;
    s_axi.s_axi_rlast   = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi.s_axi_arready = 1'b1;
        if (s_axi.s_axi_arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        s_axi.s_axi_rvalid = 1'b1;
        s_axi.s_axi_rlast  = r_last_beat;
        if (s_axi.s_axi_rready && r_last_beat) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        r_addr <= s_axi.s_axi_araddr;
        r_len  <= s_axi.s_axi_arlen;
        r_cnt  <= '0;
      end else if (r_hs && !r_last_beat) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (ar_hs || (r_hs && !r_last_beat)) begin
        rdata_q <= r_load_ok ? mem[r_load_addr[IDX_W-1:0]] : '0;
        rresp_q <= r_load_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_hs) begin
        rdata_q <= '0;
        rresp_q <= RESP_OKAY;
      end
    end
  end
endmodule

// File: tb/tb_av2_axi_mem_slave.sv
// Directed bench for av2_axi_mem_slave: a table of write/readback bursts plus
// hand-written sequences for B backpressure, read-before-write and mid-burst reset.
module tb_av2_axi_mem_slave;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int MW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  av2_axi_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  av2_axi_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_axi (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    int            wlast_beat;
    logic [1:0]    bresp;
    logic [7:0]    rpat;
  } vec_t;

  vec_t          vecs [8];
  logic [DW-1:0] exp_mem [MW];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s got timeout expected handshake", name);
  endtask

  function automatic logic [DW-1:0] mk(input logic [7:0] v, input int i);
    return {4{16'hA5A5, v, 8'(i)}};
  endfunction

  task automatic check_reset_outputs();
    check("rst_awready", 128'(bus.s_axi_awready), 128'(1));
    check("rst_arready", 128'(bus.s_axi_arready), 128'(1));
    check("rst_wready",  128'(bus.s_axi_wready),  128'(0));
    check("rst_bvalid",  128'(bus.s_axi_bvalid),  128'(0));
    check("rst_bresp",   128'(bus.s_axi_bresp),   128'(0));
    check("rst_rvalid",  128'(bus.s_axi_rvalid),  128'(0));
    check("rst_rlast",   128'(bus.s_axi_rlast),   128'(0));
    check("rst_rresp",   128'(bus.s_axi_rresp),   128'(0));
    check("rst_rdata",   bus.s_axi_rdata,         '0);
  endtask

  task automatic aw_send(input logic [AW-1:0] addr, input logic [7:0] len);
    int g = 0;
    bus.s_axi_awaddr  = addr;
    bus.s_axi_awlen   = len;
    bus.s_axi_awvalid = 1'b1;
    while (!bus.s_axi_awready && g < 50) begin @(posedge clk); #1; g++; end
    if (g >= 50) timeout("aw_wait");
    @(posedge clk); #1;
    bus.s_axi_awvalid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len,
                          input int wl, input logic [7:0] v);
    aw_send(addr, len);
    for (int i = 0; i <= int'(len); i++) begin
      int g = 0;
      logic [AW-1:0] a;
      a = addr + AW'(i);
      bus.s_axi_wdata  = mk(v, i);
      bus.s_axi_wlast  = (i == wl);
      bus.s_axi_wvalid = 1'b1;
      while (!bus.s_axi_wready && g < 50) begin @(posedge clk); #1; g++; end
      if (g >= 50) timeout("w_wait");
      @(posedge clk); #1;
      if (a < AW'(MW)) exp_mem[a] = mk(v, i);
    end
    bus.s_axi_wvalid = 1'b0;
    bus.s_axi_wlast  = 1'b0;
  endtask

  task automatic b_accept(input logic [1:0] resp);
    check("b_valid", 128'(bus.s_axi_bvalid), 128'(1));
    check("b_resp",  128'(bus.s_axi_bresp),  128'(resp));
    bus.s_axi_bready = 1'b1;
    @(posedge clk); #1;
    bus.s_axi_bready = 1'b0;
    check("b_drop",     128'(bus.s_axi_bvalid),  128'(0));
    check("aw_reready", 128'(bus.s_axi_awready), 128'(1));
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len, input logic [7:0] rpat);
    int g = 0;
    int beat = 0;
    int cyc = 0;
    bus.s_axi_araddr  = addr;
    bus.s_axi_arlen   = len;
    bus.s_axi_arvalid = 1'b1;
    while (!bus.s_axi_arready && g < 50) begin @(posedge clk); #1; g++; end
    if (g >= 50) timeout("ar_wait");
    @(posedge clk); #1;
    bus.s_axi_arvalid = 1'b0;
    while (beat <= int'(len) && cyc < 8 * (int'(len) + 2)) begin
      logic [AW-1:0] a;
      logic          ok;
      a  = addr + AW'(beat);
      ok = a < AW'(MW);
      bus.s_axi_rready = rpat[cyc % 8];
      check("r_valid", 128'(bus.s_axi_rvalid), 128'(1));
      check("r_data",  bus.s_axi_rdata, ok ? exp_mem[a] : '0);
      check("r_resp",  128'(bus.s_axi_rresp), ok ? 128'(0) : 128'(2));
      check("r_last",  128'(bus.s_axi_rlast), 128'(beat == int'(len)));
      @(posedge clk); #1;
      if (bus.s_axi_rready) beat++;
      cyc++;
    end
    if (beat <= int'(len)) timeout("r_beats");
    bus.s_axi_rready = 1'b0;
    check("r_end_valid", 128'(bus.s_axi_rvalid), 128'(0));
    check("r_end_last",  128'(bus.s_axi_rlast),  128'(0));
  endtask

  initial begin
    vecs[0] = '{addr: 5,       len: 0, wlast_beat: 0, bresp: 2'b00, rpat: 8'hFF};
    vecs[1] = '{addr: 16,      len: 3, wlast_beat: 3, bresp: 2'b00, rpat: 8'h55};
    vecs[2] = '{addr: MW - 2,  len: 3, wlast_beat: 3, bresp: 2'b10, rpat: 8'hFF};
    vecs[3] = '{addr: 30,      len: 1, wlast_beat: 1, bresp: 2'b00, rpat: 8'h33};
    vecs[4] = '{addr: 40,      len: 2, wlast_beat: 0, bresp: 2'b10, rpat: 8'hFF};
    vecs[5] = '{addr: 0,       len: 7, wlast_beat: 7, bresp: 2'b00, rpat: 8'hFF};
    vecs[6] = '{addr: MW - 1,  len: 0, wlast_beat: 0, bresp: 2'b00, rpat: 8'hFF};
    vecs[7] = '{addr: MW,      len: 0, wlast_beat: 0, bresp: 2'b10, rpat: 8'hFF};

    bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata  = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) begin
      do_write(vecs[k].addr, vecs[k].len, vecs[k].wlast_beat, 8'(k));
      b_accept(vecs[k].bresp);
      do_read(vecs[k].addr, vecs[k].len, vecs[k].rpat);
    end

    // Early wlast, then B held off: response must stay frozen and AW stays closed.
    do_write(20, 3, 2, 8'h40);
    for (int c = 0; c < 5; c++) begin
      check("bhold_valid",   128'(bus.s_axi_bvalid),  128'(1));
      check("bhold_resp",    128'(bus.s_axi_bresp),   128'(2'b10));
      check("bhold_awready", 128'(bus.s_axi_awready), 128'(0));
      @(posedge clk); #1;
    end
    b_accept(2'b10);
    do_read(20, 3, 8'hFF);

    // W beat and AR to the same word on the same edge: read sees the old word.
    do_write(7, 0, 0, 8'h50);
    b_accept(2'b00);
    aw_send(7, 0);
    bus.s_axi_wdata   = mk(8'h51, 0);
    bus.s_axi_wlast   = 1'b1;
    bus.s_axi_wvalid  = 1'b1;
    bus.s_axi_araddr  = 7;
    bus.s_axi_arlen   = 0;
    bus.s_axi_arvalid = 1'b1;
    check("rbw_wready",  128'(bus.s_axi_wready),  128'(1));
    check("rbw_arready", 128'(bus.s_axi_arready), 128'(1));
    @(posedge clk); #1;
    bus.s_axi_wvalid  = 1'b0;
    bus.s_axi_wlast   = 1'b0;
    bus.s_axi_arvalid = 1'b0;
    check("rbw_rvalid", 128'(bus.s_axi_rvalid), 128'(1));
    check("rbw_old",    bus.s_axi_rdata,        mk(8'h50, 0));
    check("rbw_rlast",  128'(bus.s_axi_rlast),  128'(1));
    bus.s_axi_rready = 1'b1;
    b_accept(2'b00);
    bus.s_axi_rready = 1'b0;
    check("rbw_rdone", 128'(bus.s_axi_rvalid), 128'(0));
    exp_mem[7] = mk(8'h51, 0);
    do_read(7, 0, 8'hFF);

    // Reset asserted while beat 2 of a 4-beat write is pending.
    aw_send(48, 3);
    for (int i = 0; i < 2; i++) begin
      bus.s_axi_wdata  = mk(8'h60, i);
      bus.s_axi_wlast  = 1'b0;
      bus.s_axi_wvalid = 1'b1;
      check("rstw_wready", 128'(bus.s_axi_wready), 128'(1));
      @(posedge clk); #1;
      exp_mem[48 + i] = mk(8'h60, i);
    end
    bus.s_axi_wdata = mk(8'h60, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    bus.s_axi_wvalid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(48, 1, 8'hFF);
    do_write(48, 3, 3, 8'h70);
    b_accept(2'b00);
    do_read(48, 3, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "global timeout");
  end
endmodule
